// File: rtl/adc_control_nonbinary.sv
// SAR controller for a 12-bit ADC with a redundant (non-binary) cap DAC:
// one sample cycle, then 15 weighted decisions; the 4 LSB steps may be
// repeated N times and majority-voted.
// Ports: clk, rst (sync, active-high), comparator_in, avg_control[2:0]
//   -> sample, nsample, enable, conv_finished, p_switch, n_switch, result.
// Build option: define ADC_AVERAGING_EN to enable LSB averaging; without it
//   avg_control is ignored and every step takes a single cycle.
module adc_control_nonbinary #(
  parameter int MATRIX_BITS = 12
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   comparator_in,
  input  logic [2:0]             avg_control,
  output logic                   sample,
  output logic                   nsample,
  output logic                   enable,
  output logic                   conv_finished,
  output logic [MATRIX_BITS-1:0] p_switch,
  output logic [MATRIX_BITS-1:0] n_switch,
  output logic [MATRIX_BITS-1:0] result
);

  typedef enum logic {
    S_SAMPLE,
    S_CONVERT
  } state_t;

  state_t state_q, state_d;

  logic [3:0]             step_q, step_d;
  logic [MATRIX_BITS-1:0] acc_q, acc_d;
  logic [MATRIX_BITS-1:0] result_q, result_d;
  logic                   fin_q, fin_d;

  logic [12:0]            trial;
  logic [MATRIX_BITS-1:0] acc_upd;
  logic                   step_done;
  logic                   take;

  function automatic logic [11:0] weight(input logic [3:0] k);
    logic [11:0] w;
    unique case (k)
      4'd1:    w = 12'd2048;
      4'd2:    w = 12'd806;
      4'd3:    w = 12'd486;
      4'd4:    w = 12'd300;
      4'd5:    w = 12'd180;
      4'd6:    w = 12'd108;
      4'd7:    w = 12'd65;
      4'd8:    w = 12'd39;
      4'd9:    w = 12'd23;
      4'd10:   w = 12'd15;
      4'd11:   w = 12'd12;
      4'd12:   w = 12'd6;
      4'd13:   w = 12'd4;
      4'd14:   w = 12'd2;
      4'd15:   w = 12'd1;
      default: w = 12'd0;
    endcase
    return w;
  endfunction

  // Redundant weights sum to 4095, so acc + weight never exceeds 12 bits.
  assign trial = {1'b0, acc_q} + {1'b0, weight(step_q)};

`ifdef ADC_AVERAGING_EN
  logic [2:0] avg_q, avg_d;
  logic [5:0] rep_q, rep_d;
  logic [5:0] ones_q, ones_d;
  logic [5:0] n_cnt;
  logic [5:0] n_last;
  logic [6:0] ones_nx;
  logic       lsb;
  logic       vote;

  always_comb begin
    n_cnt = 6'd32;
    unique case (avg_q)
      3'b000:  n_cnt = 6'd1;
      3'b001:  n_cnt = 6'd4;
      3'b010:  n_cnt = 6'd8;
      3'b011:  n_cnt = 6'd16;
      default: n_cnt = 6'd32;
    endcase
  end

  assign n_last  = n_cnt - 6'd1;
  assign lsb     = (step_q >= 4'd12);
  assign ones_nx = {1'b0, ones_q} + {6'd0, comparator_in};
  // Strict majority: a tie (2*ones == N) adds nothing.
  assign vote    = ({ones_nx, 1'b0} > {2'b00, n_cnt});
  assign step_done = !lsb || (rep_q == n_last);
  assign take      = lsb ? vote : comparator_in;
`else
  logic unused_avg;

  assign unused_avg = ^avg_control;
  assign step_done  = 1'b1;
  assign take       = comparator_in;
`endif

  assign acc_upd = take ? trial[MATRIX_BITS-1:0] : acc_q;

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    acc_d    = acc_q;
    result_d = result_q;
    fin_d    = 1'b0;
`ifdef ADC_AVERAGING_EN
    avg_d    = avg_q;
    rep_d    = rep_q;
    ones_d   = ones_q;
`endif
    unique case (state_q)
      S_SAMPLE: begin
        acc_d   = '0;
        step_d  = 4'd1;
        state_d = S_CONVERT;
`ifdef ADC_AVERAGING_EN
        avg_d   = avg_control;
        rep_d   = '0;
        ones_d  = '0;
`endif
      end
      S_CONVERT: begin
        if (step_done) begin
`ifdef ADC_AVERAGING_EN
          rep_d  = '0;
          ones_d = '0;
`endif
          if (step_q == 4'd15) begin
            result_d = acc_upd;
            fin_d    = 1'b1;
            acc_d    = '0;
            step_d   = 4'd1;
            state_d  = S_SAMPLE;
          end else begin
            acc_d  = acc_upd;
            step_d = step_q + 4'd1;
          end
        end else begin
`ifdef ADC_AVERAGING_EN
          rep_d  = rep_q + 6'd1;
          ones_d = ones_nx[5:0];
`endif
        end
      end
      default: state_d = S_SAMPLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_SAMPLE;
      step_q   <= 4'd1;
      acc_q    <= '0;
      result_q <= '0;
      fin_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      fin_q    <= fin_d;
    end
  end

`ifdef ADC_AVERAGING_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      avg_q  <= 3'b000;
      rep_q  <= '0;
      ones_q <= '0;
    end else begin
      avg_q  <= avg_d;
      rep_q  <= rep_d;
      ones_q <= ones_d;
    end
  end
`endif

  assign sample        = (state_q == S_SAMPLE);
  assign nsample       = ~sample;
  assign enable        = (state_q == S_CONVERT);
  assign conv_finished = fin_q;
  assign result        = result_q;
  assign p_switch = enable ? trial[MATRIX_BITS-1:0] : '0;
  assign n_switch = enable ? ~trial[MATRIX_BITS-1:0] : '0;

endmodule

// File: tb/tb_adc_control_nonbinary.sv
// Bench for adc_control_nonbinary: abstract conversion model checked
// every cycle, plus hand-computed result/period literals.
module tb_adc_control_nonbinary;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        comparator_in = 1'b0;
  logic [2:0]  avg_control = 3'b000;
  logic        sample, nsample, enable, conv_finished;
  logic [11:0] p_switch, n_switch, result;

  adc_control_nonbinary #(.MATRIX_BITS(12)) dut (
    .clk(clk), .rst(rst),
    .comparator_in(comparator_in),
    .avg_control(avg_control),
    .sample(sample), .nsample(nsample),
    .enable(enable),
    .conv_finished(conv_finished),
    .p_switch(p_switch), .n_switch(n_switch),
    .result(result)
  );

  always #5 clk = ~clk;

`ifdef ADC_AVERAGING_EN
  localparam int P4 = 28;
  localparam int P8 = 44;
  localparam int P32 = 140;
  localparam int R_AVG8 = 494;
`else
  localparam int P4 = 16;
  localparam int P8 = 16;
  localparam int P32 = 16;
  localparam int R_AVG8 = 498;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int W[16] = '{0, 2048, 806, 486, 300, 180, 108, 65,
                39, 23, 15, 12, 6, 4, 2, 1};

  // Model: cycle index within conversion (0 = SAMPLE).
  int  m_t = 0;
  int  m_n = 1;
  int  m_acc = 0;
  int  m_ones = 0;
  int  m_res = 0;
  bit  m_fin = 0;
  bit  m_ok = 0;

  logic [15:0] cfg_mask = '0;
  int          cfg_tgt[4] = '{0, 0, 0, 0};

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  function automatic int nsel(input logic [2:0] a);
`ifdef ADC_AVERAGING_EN
    case (a)
      3'b000:  return 1;
      3'b001:  return 4;
      3'b010:  return 8;
      3'b011:  return 16;
      default: return 32;
    endcase
`else
    return 1;
`endif
  endfunction

  function automatic int step_of(input int t, input int n);
    if (t <= 11) return t;
    return 12 + (t - 12) / n;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_t = 0; m_n = 1; m_acc = 0; m_ones = 0;
      m_res = 0; m_fin = 0; m_ok = 1;
    end else begin
      if (m_t == 0) begin
        m_n = nsel(avg_control);
        m_acc = 0;
        m_ones = 0;
      end else if (m_t <= 11) begin
        if (comparator_in) m_acc += W[m_t];
      end else begin
        m_ones += int'(comparator_in);
        if ((m_t - 12) % m_n == m_n - 1) begin
          if (2 * m_ones > m_n) m_acc += W[step_of(m_t, m_n)];
          m_ones = 0;
        end
      end
      if (m_t == 11 + 4 * m_n) begin
        m_res = m_acc;
        m_fin = 1;
        m_t = 0;
      end else begin
        m_fin = 0;
        m_t++;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    int ep;
    if (m_ok) begin
      ep = (m_t == 0) ? 0 : (m_acc + W[step_of(m_t, m_n)]) & 12'hFFF;
      chk("sample", int'(sample), int'(m_t == 0));
      chk("nsample", int'(nsample), int'(m_t != 0));
      chk("enable", int'(enable), int'(m_t != 0));
      chk("p_switch", int'(p_switch), ep);
      chk("n_switch", int'(n_switch), (m_t == 0) ? 0 : (~ep) & 12'hFFF);
      chk("result", int'(result), m_res);
      chk("conv_finished", int'(conv_finished), int'(m_fin));
    end
  end

  // Comparator stimulus from the per-step mask / LSB ones targets.
  always @(negedge clk) begin
    int k;
    int rep;
    if (m_t == 0) begin
      comparator_in = 1'b0;
    end else if (m_t <= 11) begin
      comparator_in = cfg_mask[m_t];
    end else begin
      k = step_of(m_t, m_n);
      rep = (m_t - 12) % m_n;
      comparator_in = (rep < cfg_tgt[k - 12]);
    end
  end

  // Call at the negedge of a SAMPLE cycle.
  task automatic run_conv(input string nm, input logic [2:0] avg,
                          input logic [15:0] mask,
                          input int t0, input int t1,
                          input int t2, input int t3,
                          input int exp_res, input int exp_per,
                          input bit chk_p, input bit chg);
    int c0;
    bit done;
    avg_control = avg;
    cfg_mask = mask;
    cfg_tgt = '{t0, t1, t2, t3};
    c0 = cyc;
    done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      @(negedge clk);
      if (chg && i == 4) avg_control = 3'b100;
      if (chk_p && m_t == 3) chk({nm, "_p3"}, int'(p_switch), 1292);
      if (conv_finished) done = 1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got no conv_finished expected pulse", nm);
    end else begin
      chk({nm, "_result"}, int'(result), exp_res);
      chk({nm, "_period"}, cyc - c0, exp_per);
    end
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_sample", int'(sample), 1);
    chk("rst_nsample", int'(nsample), 0);
    chk("rst_enable", int'(enable), 0);
    chk("rst_p", int'(p_switch), 0);
    chk("rst_n", int'(n_switch), 0);
    chk("rst_result", int'(result), 0);
    chk("rst_fin", int'(conv_finished), 0);
    rst = 1'b0;

    run_conv("a0_s2", 3'b000, 16'h0004, 0, 0, 0, 0, 806, 16, 1, 0);
    run_conv("a0_lsb", 3'b000, 16'h0000, 1, 1, 1, 1, 13, 16, 0, 0);
    run_conv("a0_s1", 3'b000, 16'h0002, 0, 0, 0, 0, 2048, 16, 0, 0);
    run_conv("a1_s1", 3'b001, 16'h0002, 0, 0, 0, 0, 2048, P4, 0, 1);
    run_conv("a2_vote", 3'b010, 16'h0008, 5, 4, 8, 0,
             R_AVG8, P8, 0, 0);
    run_conv("a4_all1", 3'b100, 16'hFFFE, 32, 32, 32, 32,
             4095, P32, 0, 0);
    run_conv("a0_all0", 3'b000, 16'h0000, 0, 0, 0, 0, 0, 16, 0, 0);
    run_conv("a0_s1b", 3'b000, 16'h0002, 0, 0, 0, 0, 2048, 16, 0, 0);

    avg_control = 3'b000;
    cfg_mask = 16'h0020;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_sample", int'(sample), 1);
    chk("mid_rst_nsample", int'(nsample), 0);
    chk("mid_rst_enable", int'(enable), 0);
    chk("mid_rst_p", int'(p_switch), 0);
    chk("mid_rst_n", int'(n_switch), 0);
    chk("mid_rst_result", int'(result), 0);
    chk("mid_rst_fin", int'(conv_finished), 0);
    rst = 1'b0;

    run_conv("post_rst", 3'b000, 16'h0000, 1, 1, 1, 1, 13, 16, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/adc_control_nonbinary.md
Name: adc_control_nonbinary

Overview:
Digital SAR controller for a 12-bit charge-redistribution ADC with a non-binary (redundant) weighted capacitor DAC. It sequences sample → 15 successive-approximation decisions, drives the P/N DAC switch matrix, and accumulates a 12-bit binary result. The four least-significant decisions can be repeated and majority-voted (averaging) to suppress comparator noise. It sits between the analog comparator/capacitor matrix and the digital readout.

Parameters:
MATRIX_BITS, 12, width of result and of the p_switch/n_switch buses. The weight table below is defined for 12 only.

Ports:
clk  input  1  system clock; all logic on the rising edge
rst  input  1  synchronous reset, active-high
comparator_in  input  1  comparator decision; 1 = input above current DAC trial level
avg_control  input  3  averaging select for the LSB steps
sample  output  1  high while the sampling switches are closed
nsample  output  1  always the inverse of sample
enable  output  1  comparator enable; high during decision steps
conv_finished  output  1  one-cycle pulse when result is updated
p_switch  output  MATRIX_BITS  P-side DAC switch code
n_switch  output  MATRIX_BITS  N-side DAC switch code
result  output  MATRIX_BITS  last completed conversion, registered

Behaviour:
- Decision weights, steps 1..15: 2048, 806, 486, 300, 180, 108, 65, 39, 23, 15, 12, 6, 4, 2, 1. They sum to 4095.
- Steps 1–11 are single-cycle MSB steps. Steps 12–15 are the averaged LSB steps.
- Repeat count N per averaged step, from avg_control:
  - 000 → 1
  - 001 → 4
  - 010 → 8
  - 011 → 16
  - 100–111 → 32
- avg_control is latched in the SAMPLE cycle and held constant for the whole conversion.
- States:
  - SAMPLE: 1 cycle. sample=1, enable=0, p_switch=0, n_switch=0. The accumulator acc is cleared to 0.
  - CONVERT: steps 1..15. enable=1, sample=0.
    - Trial value = acc + weight[k]. p_switch = trial, n_switch = ~trial, truncated to MATRIX_BITS.
    - comparator_in is sampled at the rising edge that ends each cycle.
    - MSB step: comparator_in=1 → acc += weight[k]. Advance after 1 cycle.
    - Averaged step: a 6-bit counter tallies ones over N cycles. Add the weight only if 2·ones > N; a tie adds nothing. Advance after N cycles. The counter clears per step.
    - After step 15 the next state is SAMPLE.
- At the edge closing step 15:
  - result ← final acc.
  - conv_finished is asserted for exactly one cycle, coinciding with the following SAMPLE cycle.
- Conversions repeat back-to-back with no idle state. Period = 1 + 11 + 4·N cycles: 16 for N=1, 140 for N=32.
- No overflow is possible, since the maximum acc is 4095. Arithmetic uses 13-bit intermediates.
- Reset, including mid-conversion:
  - State → SAMPLE; counters and acc → 0; avg latch → 000.
  - result=0, conv_finished=0, sample=1, nsample=0, enable=0, p_switch=0, n_switch=0.
  - The first SAMPLE cycle starts on the first clock after rst deasserts.
- sample and nsample are never equal. enable and sample are never both high.

Optional Feature:
ADC_AVERAGING_EN.
- Defined: averaging works as above.
- Undefined: avg_control is ignored and N=1 always, so the period is fixed at 16 cycles. The ones-counter and avg latch are not implemented, and all other behaviour is identical.

Test Plan:
- Reset: assert rst mid-conversion → next cycle sample=1, nsample=0, enable=0, p_switch=n_switch=0, result=0, conv_finished=0; after release, first SAMPLE is followed by 15 decision cycles.
- avg 000, comparator 1 only in step 2 → p_switch=806+486 during step 3; result=806; conv_finished pulses 16 cycles after SAMPLE.
- avg 000, comparator 1 only in steps 12–15 → result=13; a comparator 1 only in step 1 → result=2048.
- avg 001, comparator 1 only in step 1 → result=2048, period 28 cycles; avg_control changed mid-conversion has no effect on it.
- avg 010, step 12 ones=5/8 (adds 6), step 13 ones=4/8 (tie, no add), step 14 ones=8/8 (adds 2), plus step 3 (adds 486) → result=494.
- avg 100, comparator held 1 → result=4095, period 140 cycles; then avg 000 with comparator held 0 → result=0 after 16 cycles.
